uart_rx_buffer: RTL and testbench
=================================

# uart_rx_buffer

Receive-side buffer placed directly downstream of the UART receiver. It captures each completed 7-bit character together with its framing-error (`broke`) status into a FIFO. It exposes the entries to the consuming logic through a registered read handshake. It also maintains sticky overflow and saturating error statistics, so that software-facing logic can drain characters at its own pace.

## Interface
Parameters:
- `DATA_W`, default 7: character width; matches the receiver's `out_rec` width.
- `DEPTH`, default 8: FIFO entries; must be a power of two and at least 2.
- `ERR_W`, default 8: width of the framing-error counter.

Ports:
- `clk`, input, 1: single clock for all logic.
- `rst`, input, 1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `rx_data`, input, DATA_W: received character.
- `rx_valid`, input, 1: one-cycle strobe marking that `rx_data` and `rx_broke` hold a completed frame.
- `rx_broke`, input, 1: framing error for the frame strobed by `rx_valid`.
- `rd_en`, input, 1: consumer read request.
- `clr_stat`, input, 1: clears `overflow` and `err_count`.
- `rd_data`, output, DATA_W: registered read data.
- `rd_err`, output, 1: registered `broke` bit stored with `rd_data`.
- `rd_valid`, output, 1: one-cycle pulse; `rd_data` and `rd_err` are valid.
- `empty`, output, 1: FIFO holds 0 entries.
- `full`, output, 1: FIFO holds DEPTH entries.
- `count`, output, log2(DEPTH)+1: number of stored entries.
- `overflow`, output, 1: sticky flag; a frame was dropped because the FIFO was full.
- `err_count`, output, ERR_W: number of frames with `rx_broke`=1, saturating at all-ones.

## Operation
- Storage: DEPTH x (DATA_W+1) entries, each `{rx_broke, rx_data}`. Write pointer and read pointer are log2(DEPTH) bits and wrap modulo DEPTH. `count` is a separate counter.
- Write: on `rx_valid`=1 with a free slot, store the entry at the write pointer and advance the pointer. A slot is free when `full`=0, or when `full`=1 and a read is accepted in the same cycle.
- Drop: `rx_valid`=1 with no free slot discards the entry and sets `overflow`=1. Pointers and `count` are unchanged.
- Read: `rd_en`=1 with `empty`=0 is accepted. The entry at the read pointer is registered into `rd_data`/`rd_err`, the read pointer advances, and `rd_valid`=1 on the next cycle. `rd_en` while `empty`=1 is ignored; `rd_valid` stays 0 and nothing changes.
- No fall-through: with `empty`=1, a simultaneous write and read accepts the write only.
- Simultaneous accepted write and read: `count` is unchanged.
- `rd_data`/`rd_err` hold their last value while `rd_valid`=0.
- Error counter: increments on every `rx_valid`=1 with `rx_broke`=1, whether or not the entry is dropped. It saturates at 2^ERR_W-1.
- `clr_stat`=1: next cycle `overflow`=0 and `err_count`=0. Clear wins over a drop or error event in the same cycle; that event is not recorded.
- Flags: `empty` = (`count`==0) and `full` = (`count`==DEPTH). Both are derived from the registered `count`.

## Timing
- Reset (`rst`=1 at a clock edge): pointers=0, `count`=0, `empty`=1, `full`=0, `rd_valid`=0, `rd_data`=0, `rd_err`=0, `overflow`=0, `err_count`=0. Stored contents are don't-care.
- Reset has priority over all inputs. A reset asserted mid-stream discards all entries and any pending `rd_valid`; the cycle after reset shows the reset values.
- Write-to-visibility latency: an entry written at edge N makes `empty`=0 and `count`+1 visible after edge N. An `rd_en` sampled at edge N+1 returns that entry with `rd_valid`=1 after edge N+1.
- Read latency: exactly 1 cycle from an accepted `rd_en` to `rd_valid`.
- Back-to-back: `rd_en` held high drains one entry per cycle, with one `rd_valid` per cycle.
- `overflow` and `err_count` update one cycle after the causing `rx_valid`.

## Test plan
- Reset, then strobe 3 frames 0x41, 0x42(broke=1), 0x43, then `rd_en` for 3 cycles -> `rd_data` sequence 0x41/0x42/0x43, `rd_err` 0/1/0, `err_count`=1, `empty`=1 at end.
- Write 8 frames (DEPTH=8) -> `full`=1, `count`=8. Write a 9th frame 0x7F -> `overflow`=1, contents unchanged. Drain all -> 8 original values in order.
- With `full`=1, assert `rx_valid` (0x55) and `rd_en` in the same cycle -> oldest entry read, 0x55 accepted, `count`=8, `overflow`=0.
- With `empty`=1, assert `rd_en` alone -> `rd_valid`=0. Assert `rd_en` together with `rx_valid` (0x12) -> `count`=1 and no `rd_valid`; next `rd_en` returns 0x12.
- Use ERR_W=2 and send 5 broke frames -> `err_count` saturates at 3. Then `clr_stat` coincident with a broke frame -> `err_count`=0 and `overflow`=0.
- Fill 5 entries interleaved with 20 pointer wrap-arounds of writes and reads, then assert `rst` mid-stream -> next cycle `empty`=1, `rd_valid`=0, `count`=0; subsequent write/read of 0x2A returns 0x2A.

Source files
------------

// File: rtl/uart_rx_buffer.sv
// Receive FIFO behind the UART receiver: stores {broke, data} per frame, registered read
// port, sticky overflow flag and saturating framing-error counter.
module uart_rx_buffer #(
    parameter int DATA_W = 7,
    parameter int DEPTH  = 8,
    parameter int ERR_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          rx_data,
    input  logic                       rx_valid,
    input  logic                       rx_broke,
    input  logic                       rd_en,
    input  logic                       clr_stat,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_err,
    output logic                       rd_valid,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [ERR_W-1:0]           err_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W:0]  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             rd_accept;
    logic             wr_accept;
    logic             drop;
    logic             err_event;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    // A read frees the slot in the same cycle, so a full FIFO still takes a write then.
    // Reads require a stored entry, which rules out fall-through when empty.
    assign rd_accept = rd_en && !empty;
    assign wr_accept = rx_valid && (!full || rd_accept);
    assign drop      = rx_valid && !wr_accept;
    assign err_event = rx_valid && rx_broke;

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= {rx_broke, rx_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_err   <= 1'b0;
        end else begin
            rd_valid <= rd_accept;
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_accept) begin
                {rd_err, rd_data} <= mem[rd_ptr];
                rd_ptr            <= rd_ptr + PTR_W'(1);
            end
            if (wr_accept && !rd_accept) begin
                count <= count + CNT_W'(1);
            end else if (rd_accept && !wr_accept) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Clear takes priority over a same-cycle drop or framing error.
    always_ff @(posedge clk) begin
        if (rst || clr_stat) begin
            overflow  <= 1'b0;
            err_count <= '0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end
            if (err_event && (err_count != {ERR_W{1'b1}})) begin
                err_count <= err_count + ERR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Self-checking bench for uart_rx_buffer: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, and randomized traffic.
module tb_uart_rx_buffer;

    localparam int DATA_W = 7;
    localparam int DEPTH  = 8;
    localparam int ERR_W  = 2;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_broke;
    logic              rd_en;
    logic              clr_stat;
    logic [DATA_W-1:0] rd_data;
    logic              rd_err;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic [3:0]        count;
    logic              overflow;
    logic [ERR_W-1:0]  err_count;

    int n_checks = 0;
    int n_errors = 0;

    uart_rx_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_broke(rx_broke),
        .rd_en(rd_en), .clr_stat(clr_stat), .rd_data(rd_data), .rd_err(rd_err),
        .rd_valid(rd_valid), .empty(empty), .full(full), .count(count),
        .overflow(overflow), .err_count(err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: FIFO as a queue, statistics as plain integers.
    logic [DATA_W:0] m_q[$];
    int              m_err = 0;
    bit              m_ovf = 0;
    bit              m_rv  = 0;
    logic [DATA_W:0] m_rd  = '0;
    bit              started = 0;

    always @(posedge clk) begin
        started = 1;
        if (rst) begin
            m_q.delete();
            m_err = 0;
            m_ovf = 0;
            m_rv  = 0;
            m_rd  = '0;
        end else begin
            bit rd_ok;
            bit wr_ok;
            rd_ok = rd_en && (m_q.size() > 0);
            wr_ok = rx_valid && ((m_q.size() < DEPTH) || rd_ok);
            m_rv  = rd_ok;
            if (rd_ok) m_rd = m_q.pop_front();
            if (wr_ok) m_q.push_back({rx_broke, rx_data});
            if (clr_stat) begin
                m_ovf = 0;
                m_err = 0;
            end else begin
                if (rx_valid && !wr_ok) m_ovf = 1;
                if (rx_valid && rx_broke && m_err < ERR_MAX) m_err++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("rd_valid", 32'(rd_valid), 32'(m_rv));
            check("rd_data", 32'(rd_data), 32'(m_rd[DATA_W-1:0]));
            check("rd_err", 32'(rd_err), 32'(m_rd[DATA_W]));
            check("count", 32'(count), 32'(m_q.size()));
            check("empty", 32'(empty), 32'(m_q.size() == 0));
            check("full", 32'(full), 32'(m_q.size() == DEPTH));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("err_count", 32'(err_count), 32'(m_err));
        end
    end

    // Apply one cycle of inputs, return at the following falling edge with inputs idle.
    task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic b,
                        input logic re, input logic c);
        rx_valid = v;
        rx_data  = d;
        rx_broke = b;
        rd_en    = re;
        clr_stat = c;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_broke = 1'b0;
        rd_en    = 1'b0;
        clr_stat = 1'b0;
    endtask

    task automatic write(input logic [DATA_W-1:0] d, input logic b);
        step(1'b1, d, b, 1'b0, 1'b0);
    endtask

    task automatic read_expect(input string name, input logic [DATA_W-1:0] d, input logic e);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check({name, "_valid"}, 32'(rd_valid), 32'd1);
        check({name, "_data"}, 32'(rd_data), 32'(d));
        check({name, "_err"}, 32'(rd_err), 32'(e));
    endtask

    initial begin
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_data  = '0;
        rx_broke = 1'b0;
        rd_en    = 1'b0;
        clr_stat = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);

        // Three frames, middle one broken.
        write(7'h41, 1'b0);
        write(7'h42, 1'b1);
        write(7'h43, 1'b0);
        check("three_count", 32'(count), 32'd3);
        read_expect("rd0", 7'h41, 1'b0);
        read_expect("rd1", 7'h42, 1'b1);
        read_expect("rd2", 7'h43, 1'b0);
        check("three_err", 32'(err_count), 32'd1);
        check("three_empty", 32'(empty), 32'd1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("rd_valid_pulse", 32'(rd_valid), 32'd0);
        check("rd_data_hold", 32'(rd_data), 32'h43);

        // Fill, overflow, drain.
        for (int i = 0; i < DEPTH; i++) write(7'(8'h20 + i), 1'b0);
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(count), 32'd8);
        write(7'h7F, 1'b0);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd8);
        for (int i = 0; i < DEPTH; i++) read_expect("drain", 7'(8'h20 + i), 1'b0);
        check("drain_empty", 32'(empty), 32'd1);

        // Full FIFO with simultaneous write and read.
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("clr_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < DEPTH; i++) write(7'(8'h10 + i), 1'b0);
        step(1'b1, 7'h55, 1'b0, 1'b1, 1'b0);
        check("fullrw_data", 32'(rd_data), 32'h10);
        check("fullrw_count", 32'(count), 32'd8);
        check("fullrw_ovf", 32'(overflow), 32'd0);
        for (int i = 1; i < DEPTH; i++) read_expect("fullrw_drain", 7'(8'h10 + i), 1'b0);
        read_expect("fullrw_last", 7'h55, 1'b0);

        // Empty FIFO: lone read ignored, read+write takes the write only.
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("empty_rd_valid", 32'(rd_valid), 32'd0);
        step(1'b1, 7'h12, 1'b0, 1'b1, 1'b0);
        check("nofall_count", 32'(count), 32'd1);
        check("nofall_valid", 32'(rd_valid), 32'd0);
        read_expect("nofall_rd", 7'h12, 1'b0);

        // Error counter saturation and clear-wins.
        for (int i = 0; i < 5; i++) write(7'(8'h60 + i), 1'b1);
        check("err_sat", 32'(err_count), 32'd3);
        for (int i = 0; i < 4; i++) write(7'h00, 1'b0);
        check("sat_ovf", 32'(overflow), 32'd1);
        step(1'b1, 7'h66, 1'b1, 1'b0, 1'b1);
        check("clr_err", 32'(err_count), 32'd0);
        check("clr_ovf2", 32'(overflow), 32'd0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Random traffic: many pointer wraps, plus a phase biased towards full.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 7'($urandom), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 31) == 0));
        for (int i = 0; i < 150; i++)
            step(1'($urandom_range(0, 3) != 0), 7'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) == 0), 1'b0);

        // Settle at 5 entries, then reset mid-stream with a read pending.
        for (int i = 0; i < 2 * DEPTH && m_q.size() != 5; i++) begin
            if (m_q.size() < 5) write(7'($urandom), 1'b0);
            else step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        end
        check("pre_rst_count", 32'(count), 32'd5);
        rst = 1'b1;
        step(1'b1, 7'h33, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        check("mid_rst_empty", 32'(empty), 32'd1);
        check("mid_rst_valid", 32'(rd_valid), 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        write(7'h2A, 1'b0);
        read_expect("post_rst", 7'h2A, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
